// File: rtl/registers_bank_pkg.sv
// Shared sizing and types for the general-purpose register file.
package registers_bank_pkg;

  localparam int DATA_WIDTH_C = 32;
  localparam int ADDR_WIDTH_C = 5;
  localparam int NUM_REGS_C   = 2 ** ADDR_WIDTH_C;

  typedef logic [ADDR_WIDTH_C-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_C-1:0] word_t;

endpackage : registers_bank_pkg

// File: rtl/registers_bank.sv
// General-purpose register file: 32x32, two combinational read ports, one synchronous write port.
// Optional macro REG_ZERO_HARDWIRED_EN makes register 0 a constant zero.
module registers_bank
  import registers_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int ADDR_WIDTH = ADDR_WIDTH_C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] data_rs,
  output logic [DATA_WIDTH-1:0] data_rt
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] registers [0:NUM_REGS-1];
  logic                  wr_allow;

`ifdef REG_ZERO_HARDWIRED_EN
  assign wr_allow = en && (rd != '0);
`else
  assign wr_allow = en;
`endif

  // Reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        registers[i] <= '0;
      end
    end else if (wr_allow) begin
      registers[rd] <= data;
    end
  end

  // No write-to-read bypass: reads see the array as it stands before the edge.
`ifdef REG_ZERO_HARDWIRED_EN
  assign data_rs = (rs == '0) ? '0 : registers[rs];
  assign data_rt = (rt == '0) ? '0 : registers[rt];
`else
  assign data_rs = registers[rs];
  assign data_rt = registers[rt];
`endif

endmodule : registers_bank

// File: tb/tb_registers_bank.sv
// Directed self-checking bench for registers_bank.
module tb_registers_bank;
  import registers_bank_pkg::*;

  logic     clk;
  logic     rst;
  logic     en;
  reg_idx_t rd;
  word_t    data;
  reg_idx_t rs;
  reg_idx_t rt;
  word_t    data_rs;
  word_t    data_rt;

  int checks;
  int errors;

  registers_bank dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rd      (rd),
    .data    (data),
    .rs      (rs),
    .rt      (rt),
    .data_rs (data_rs),
    .data_rt (data_rt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t observed, input word_t expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive inputs on the falling edge, return 1ns after the next rising edge.
  task automatic step(input logic r, input logic e, input reg_idx_t idx, input word_t val);
    @(negedge clk);
    rst  = r;
    en   = e;
    rd   = idx;
    data = val;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < NUM_REGS_C; i++) begin
      rs = reg_idx_t'(i);
      rt = reg_idx_t'(NUM_REGS_C - 1 - i);
      #1;
      check({tag, "_rs"}, data_rs, 32'h0);
      check({tag, "_rt"}, data_rt, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b0;
    en   = 1'b0;
    rd   = '0;
    data = '0;
    rs   = '0;
    rt   = '0;

    // reset edge, then release
    step(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    sweep_zero("reset");

    // write 0x1000_0000+i into registers 0..7
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, reg_idx_t'(i), 32'h1000_0000 + i);
    end
    for (int i = 0; i < 8; i++) begin
      rs = reg_idx_t'(i);
      rt = reg_idx_t'(7 - i);
      #1;
      check("wr_rs", data_rs, 32'h1000_0000 + i);
      check("wr_rt", data_rt, 32'h1000_0007 - i);
      check("wr_probe", dut.registers[i], 32'h1000_0000 + i);
    end

    // high indices exercise the upper address bits
    step(1'b1, 1'b1, 5'd31, 32'hCAFE_001F);
    step(1'b1, 1'b1, 5'd16, 32'hCAFE_0010);
    rs = 5'd31;
    rt = 5'd16;
    #1;
    check("hi_rs31", data_rs, 32'hCAFE_001F);
    check("hi_rt16", data_rt, 32'hCAFE_0010);
    rs = 5'd15;
    rt = 5'd8;
    #1;
    check("hi_rs15", data_rs, 32'h0);
    check("hi_rt8", data_rt, 32'h0);

    // en=0 must leave the target untouched
    step(1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF);
    rs = 5'd3;
    #1;
    check("wdis_probe", dut.registers[3], 32'h1000_0003);
    check("wdis_rs", data_rs, 32'h1000_0003);

    // same-cycle read of the register being written
    @(negedge clk);
    rs   = 5'd5;
    rt   = 5'd4;
    rd   = 5'd5;
    en   = 1'b1;
    data = 32'hA5A5_A5A5;
    #1;
    check("bypass_old_rs", data_rs, 32'h1000_0005);
    check("bypass_old_rt", data_rt, 32'h1000_0004);
    @(posedge clk);
    #1;
    en = 1'b0;
    check("bypass_new_rs", data_rs, 32'hA5A5_A5A5);
    check("bypass_new_rt", data_rt, 32'h1000_0004);

    // rs=rt=rd in one cycle
    @(negedge clk);
    rs   = 5'd6;
    rt   = 5'd6;
    rd   = 5'd6;
    en   = 1'b1;
    data = 32'h5A5A_0006;
    #1;
    check("same_old_rs", data_rs, 32'h1000_0006);
    check("same_old_rt", data_rt, 32'h1000_0006);
    @(posedge clk);
    #1;
    en = 1'b0;
    check("same_new_rs", data_rs, 32'h5A5A_0006);
    check("same_new_rt", data_rt, 32'h5A5A_0006);

    // reset beats a write on the same edge
    step(1'b0, 1'b1, 5'd2, 32'h0000_1234);
    rst = 1'b1;
    check("rstpri_probe", dut.registers[2], 32'h0);
    sweep_zero("rstpri");

    // register 0 behaviour depends on the build
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    rs = 5'd0;
    rt = 5'd0;
    #1;
`ifdef REG_ZERO_HARDWIRED_EN
    check("r0_rs", data_rs, 32'h0);
    check("r0_rt", data_rt, 32'h0);
    check("r0_probe", dut.registers[0], 32'h0);
`else
    check("r0_rs", data_rs, 32'hFFFF_FFFF);
    check("r0_rt", data_rt, 32'hFFFF_FFFF);
    check("r0_probe", dut.registers[0], 32'hFFFF_FFFF);
`endif
    rs = 5'd1;
    #1;
    check("r0_neighbor", data_rs, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_registers_bank
